// File: rtl/param_delay_line_if.sv
// Stream, control and status signals of the parameterised delay line.
interface param_delay_line_if #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned DROP_W = 8
);
  localparam int unsigned OCC_W = $clog2(DEPTH + 1);

  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             stall;
  logic             flush;
  logic             in_ready;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic [OCC_W-1:0] occupancy;
  logic [DROP_W-1:0] drop_cnt;

  // Producer/observer side: drives beats and control, watches results.
  modport master (
    output in_valid, in_data, stall, flush,
    input  in_ready, out_valid, out_data, occupancy, drop_cnt
  );

  // Delay line side.
  modport slave (
    input  in_valid, in_data, stall, flush,
    output in_ready, out_valid, out_data, occupancy, drop_cnt
  );
endinterface

// File: rtl/param_delay_line.sv
// Fixed-latency delay line of DEPTH register stages with stall, flush,
// occupancy tracking and a saturating count of beats refused at the input.
module param_delay_line #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned DROP_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  param_delay_line_if.slave  bus
);

  localparam int unsigned OCC_W = $clog2(DEPTH + 1);
  localparam int unsigned LAST  = DEPTH - 1;

  logic [DEPTH-1:0] valid_q;
  logic [WIDTH-1:0] data_q [DEPTH];
  logic [OCC_W-1:0] occ_q;
  logic [OCC_W-1:0] occ_next_c;
  logic [DROP_W-1:0] drop_q;
  logic             drop_event_c;
  logic             drop_sat_c;

  // Occupancy after a plain shift edge: one beat in, possibly one beat out.
  always_comb begin
    occ_next_c = occ_q;
    occ_next_c = occ_q + OCC_W'(bus.in_valid) - OCC_W'(valid_q[LAST]);
  end

  // An offered beat is lost whenever the line refuses to shift this edge.
  always_comb begin
    drop_event_c = 1'b0;
    drop_sat_c   = 1'b0;
    drop_event_c = bus.in_valid & (bus.stall | bus.flush);
    drop_sat_c   = (drop_q == {DROP_W{1'b1}});
  end

  // Stage registers: reset and flush clear, stall holds, otherwise shift.
  always_ff @(posedge clk) begin
    if (rst || bus.flush) begin
      valid_q <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        data_q[i] <= '0;
      end
    end else if (!bus.stall) begin
      valid_q[0] <= bus.in_valid;
      data_q[0]  <= bus.in_valid ? bus.in_data : '0;
      for (int i = 1; i < int'(DEPTH); i++) begin
        valid_q[i] <= valid_q[i-1];
        data_q[i]  <= data_q[i-1];
      end
    end
  end

  // Count of valid stages, maintained incrementally.
  always_ff @(posedge clk) begin
    if (rst || bus.flush) begin
      occ_q <= '0;
    end else if (!bus.stall) begin
      occ_q <= occ_next_c;
    end
  end

  // Saturating count of refused input beats; flushed stages are not counted.
  always_ff @(posedge clk) begin
    if (rst) begin
      drop_q <= '0;
    end else if (drop_event_c && !drop_sat_c) begin
      drop_q <= drop_q + DROP_W'(1);
    end
  end

  assign bus.in_ready  = !bus.stall;
  assign bus.out_valid = valid_q[LAST];
  assign bus.out_data  = valid_q[LAST] ? data_q[LAST] : '0;
  assign bus.occupancy = occ_q;
  assign bus.drop_cnt  = drop_q;

endmodule

// File: doc/param_delay_line.md
PARAM_DELAY_LINE -- requirements
Module: param_delay_line

Interface
REQ-001 Parameter WIDTH, default 8, data width in bits; legal range 1..64.
REQ-002 Parameter DEPTH, default 4, latency in clock edges; one register stage per edge; legal range 1..32.
REQ-003 Parameter DROP_W, default 8, width of the dropped-beat counter.
REQ-004 Port clk  input  1  single clock; all state updates on its rising edge.
REQ-005 Port rst  input  1  synchronous, active-high reset.
REQ-006 Port in_valid  input  1  input beat present this cycle.
REQ-007 Port in_data  input  WIDTH  input beat payload.
REQ-008 Port stall  input  1  freeze all stages this cycle.
REQ-009 Port flush  input  1  discard every beat in flight.
REQ-010 Port in_ready  output  1  equals !stall (combinational).
REQ-011 Port out_valid  output  1  valid bit of the last stage.
REQ-012 Port out_data  output  WIDTH  payload of the last stage; forced to 0 when out_valid=0.
REQ-013 Port occupancy  output  $clog2(DEPTH+1)  registered count of valid stages.
REQ-014 Port drop_cnt  output  DROP_W  registered count of beats lost to stall or flush; saturates.

Function
REQ-015 Internal state: DEPTH stages, each holding {valid, data}; stage 0 nearest the input, stage DEPTH-1 drives the outputs.
REQ-016 Priority per edge: rst > flush > stall > shift.
REQ-017 Shift (rst=0, flush=0, stall=0): stage0 <= {in_valid, in_valid ? in_data : 0}; stage[i] <= stage[i-1] for i=1..DEPTH-1.
REQ-018 Latency: a beat sampled at edge n is visible on out_valid/out_data after edge n+DEPTH-1 and remains there for exactly one cycle if no stall follows.
REQ-019 DEPTH=1: the single stage is both input and output register; latency is one edge.
REQ-020 Stall (flush=0): every stage holds value and valid bit; out_valid/out_data remain stable; in_valid=1 in this cycle drops the beat.
REQ-021 Flush: all valid bits and data cleared at the edge; occupancy <= 0; in_valid=1 in this cycle drops the beat; flush overrides stall.
REQ-022 Occupancy on shift: occ_next = occ + in_valid - stage[DEPTH-1].valid; on stall, unchanged; on flush, 0; never exceeds DEPTH.
REQ-023 drop_cnt increments by 1 per edge with in_valid=1 and (stall=1 or flush=1); beats discarded from stages by flush are not counted; holds at 2^DROP_W-1 once reached.
REQ-024 Bubbles (in_valid=0) propagate as zero-data invalid stages; no compaction of bubbles.
REQ-025 out_data shall equal the payload exactly as sampled; no reordering, duplication or loss except per REQ-020/REQ-021.

Reset
REQ-026 On an edge with rst=1: all stage valid bits and data <= 0, occupancy <= 0, drop_cnt <= 0; out_valid=0 and out_data=0 after that edge.
REQ-027 rst mid-stream discards all in-flight beats without counting them; in_valid sampled at a reset edge is ignored and not counted.
REQ-028 First beat accepted on the first edge with rst=0.
REQ-029 in_ready follows stall during reset (no reset dependency).

Verification (WIDTH=8, DEPTH=4, DROP_W=8)
REQ-030 Stream: in_data 0x11,0x22,0x33 with in_valid=1 on edges 1..3 -> out 0x11,0x22,0x33 valid after edges 4,5,6; occupancy 1,2,3,3,2,1,0.
REQ-031 Stall: beat 0xA5 at edge 1, stall=1 edges 2..3 with in_valid=1 -> 0xA5 out after edge 6, drop_cnt=2, outputs stable during stall.
REQ-032 Flush: beats 0x01..0x03 in flight, flush=1 with stall=1 and in_valid=1 -> next cycle out_valid=0, occupancy=0, drop_cnt=1.
REQ-033 Saturation: 300 cycles in_valid=1, stall=1 -> drop_cnt=255 and held.
REQ-034 Reset mid-stream: 3 beats in flight, rst=1 one edge -> out_valid=0, out_data=0, occupancy=0, drop_cnt=0; none of the 3 beats emerge.
REQ-035 Bubble pattern: in_valid 1,0,1,0 with data 0xFF each cycle -> out_valid 1,0,1,0 after edge 4, out_data 0xFF,0x00,0xFF,0x00.
